// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with sequential, absolute and relative branching.
// Single-cycle update per unstalled RUN cycle; stall freezes all sequencing state.
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_abs,
  input  logic             branch_rel,
  input  logic             cond_flag,
  input  logic [4:0]       tgt_sel,
  output logic [4:0]       lut_index,
  input  logic [7:0]       lut_value,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             fetch_valid,
  output logic             branch_taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic            take;
  logic [PC_W-1:0] abs_tgt;
  logic [PC_W-1:0] rel_tgt;

  // The table is looked up in the same cycle the instruction is presented.
  assign lut_index = tgt_sel;

  assign take    = cond_flag & (branch_abs | branch_rel);
  assign abs_tgt = PC_W'(lut_value);
  assign rel_tgt = prog_ctr + PC_W'($signed(lut_value));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      prog_ctr     <= '0;
      taken_cnt    <= '0;
      branch_taken <= 1'b0;
      fetch_valid  <= 1'b0;
      done         <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            prog_ctr    <= '0;
            taken_cnt   <= '0;
            fetch_valid <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            // Halt outranks any branch encoded on the same instruction.
            if (halt_req) begin
              state       <= DONE;
              fetch_valid <= 1'b0;
              done        <= 1'b1;
            end else if (take) begin
              prog_ctr     <= branch_abs ? abs_tgt : rel_tgt;
              branch_taken <= 1'b1;
              if (taken_cnt != CNT_MAX)
                taken_cnt <= taken_cnt + CNT_ONE;
            end else begin
              prog_ctr <= prog_ctr + PC_ONE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          fetch_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes model expectations, a monitor pops and compares.
module tb_pc_sequencer;
  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;
  localparam int CMAX   = 65535;
  localparam int SMAX   = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start, stall, halt_req, branch_abs, branch_rel, cond_flag;
  logic [4:0]  tgt_sel;
  logic [4:0]  lut_index, lut_index_s;
  logic [7:0]  lut_value, lut_value_s;
  logic [PC_W-1:0] prog_ctr, prog_ctr_s;
  logic        fetch_valid, fetch_valid_s, branch_taken, branch_taken_s, done, done_s;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt_s;
  logic [7:0]  lut_mem [32];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int       pc;
    bit       fv;
    bit       dn;
    bit       bt;
    int       cnt;
    int       scnt;
    int       li;
  } exp_t;
  exp_t q[$];

  // Reference model state
  bit m_run, m_done;
  int m_pc, m_n;

  always #5 Clk = ~Clk;

  assign lut_value   = lut_mem[lut_index];
  assign lut_value_s = lut_mem[lut_index_s];

  pc_sequencer #(.PC_W(PC_W), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_abs(branch_abs), .branch_rel(branch_rel), .cond_flag(cond_flag),
    .tgt_sel(tgt_sel), .lut_index(lut_index), .lut_value(lut_value),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .branch_taken(branch_taken),
    .taken_cnt(taken_cnt), .done(done)
  );

  pc_sequencer #(.PC_W(PC_W), .CNT_W(2)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_abs(branch_abs), .branch_rel(branch_rel), .cond_flag(cond_flag),
    .tgt_sel(tgt_sel), .lut_index(lut_index_s), .lut_value(lut_value_s),
    .prog_ctr(prog_ctr_s), .fetch_valid(fetch_valid_s), .branch_taken(branch_taken_s),
    .taken_cnt(taken_cnt_s), .done(done_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_n = 0;
  endtask

  // Called at a falling edge; drives inputs, predicts the post-edge outputs, waits one cycle.
  task automatic step(input bit st, input bit stl, input bit hlt, input bit ba,
                      input bit br, input bit cf, input logic [4:0] ts);
    exp_t e;
    int   v, off;
    bit   bt;
    start = st; stall = stl; halt_req = hlt; branch_abs = ba;
    branch_rel = br; cond_flag = cf; tgt_sel = ts;
    bt = 0;
    v  = int'(lut_mem[ts]);
    off = (v >= 128) ? v - 256 : v;
    if (Reset_n) begin
      if (!m_run && st) begin
        m_pc = 0; m_n = 0; m_run = 1; m_done = 0;
      end else if (m_run && !stl) begin
        if (hlt) begin
          m_run = 0; m_done = 1;
        end else if (cf && ba) begin
          m_pc = v; m_n++; bt = 1;
        end else if (cf && br) begin
          m_pc = (m_pc + off + PC_MOD) % PC_MOD; m_n++; bt = 1;
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end
    e.pc = m_pc; e.fv = m_run; e.dn = m_done; e.bt = bt;
    e.cnt  = (m_n > CMAX) ? CMAX : m_n;
    e.scnt = (m_n > SMAX) ? SMAX : m_n;
    e.li   = int'(ts);
    q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc"}, int'(prog_ctr), 0);
    chk({tag, "_fv"}, int'(fetch_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_bt"}, int'(branch_taken), 0);
    chk({tag, "_cnt"}, int'(taken_cnt), 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh output set after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("prog_ctr", int'(prog_ctr), e.pc);
        chk("fetch_valid", int'(fetch_valid), int'(e.fv));
        chk("done", int'(done), int'(e.dn));
        chk("branch_taken", int'(branch_taken), int'(e.bt));
        chk("taken_cnt", int'(taken_cnt), e.cnt);
        chk("lut_index", int'(lut_index), e.li);
        chk("sat_taken_cnt", int'(taken_cnt_s), e.scnt);
        chk("sat_prog_ctr", int'(prog_ctr_s), e.pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 0;
    start = 0; stall = 0; halt_req = 0; branch_abs = 0; branch_rel = 0;
    cond_flag = 0; tgt_sel = '0;
    for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom_range(0, 255));
    lut_mem[6] = 8'd70;
    lut_mem[9] = 8'hFC;
    model_reset();
    repeat (2) @(negedge Clk);
    check_zero("reset");
    Reset_n = 1;
    step(0, 1, 1, 1, 1, 1, 5'd6);
    seq(2);

    // Sequential run then absolute jump at pc 3
    step(1, 0, 0, 0, 0, 0, 5'd0);
    seq(3);
    step(0, 0, 0, 1, 0, 1, 5'd6);
    seq(2);
    step(1, 0, 0, 0, 0, 0, 5'd0);
    // Relative branch backwards across zero, then wrap forward
    step(0, 0, 1, 0, 0, 0, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd0);
    seq(2);
    step(0, 0, 0, 0, 1, 1, 5'd9);
    seq(2);
    step(0, 0, 1, 0, 0, 0, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd0);
    seq(2);
    step(0, 0, 0, 0, 1, 0, 5'd9);
    step(0, 0, 0, 1, 1, 1, 5'd9);

    // Stalled halt+branches, then halt wins
    step(0, 1, 1, 1, 1, 1, 5'd6);
    step(0, 0, 1, 1, 1, 1, 5'd6);
    step(0, 0, 0, 1, 0, 1, 5'd6);
    seq(2);

    // Asynchronous reset mid-run at pc 40
    step(1, 0, 0, 0, 0, 0, 5'd0);
    seq(40);
    chk("pre_reset_pc", int'(prog_ctr), 40);
    #2 Reset_n = 0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge Clk);
    Reset_n = 1;
    seq(2);
    step(1, 0, 0, 0, 0, 0, 5'd0);
    seq(2);

    // Counter saturation and restart from DONE
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 5'd6);
    step(0, 0, 1, 0, 0, 0, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd0);

    // Randomised phase
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)));
    end

    @(negedge Clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, giving the program counter width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the taken-branch counter width in bits.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a program run from address 0.
REQ-006 SHALL have port stall, input, 1 bit: freeze all sequencing state this cycle.
REQ-007 SHALL have port halt_req, input, 1 bit: the current instruction is a halt.
REQ-008 SHALL have port branch_abs, input, 1 bit: the current instruction is an absolute jump.
REQ-009 SHALL have port branch_rel, input, 1 bit: the current instruction is a PC-relative branch.
REQ-010 SHALL have port cond_flag, input, 1 bit: the branch condition is true.
REQ-011 SHALL have port tgt_sel, input, 5 bits: the target-table index field of the current instruction.
REQ-012 SHALL have port lut_index, output, 5 bits: the index driven to the target lookup table.
REQ-013 SHALL have port lut_value, input, 8 bits: the target value returned combinationally by the lookup table.
REQ-014 SHALL have port prog_ctr, output, PC_W bits: the current instruction address.
REQ-015 SHALL have port fetch_valid, output, 1 bit: prog_ctr addresses a live instruction.
REQ-016 SHALL have port branch_taken, output, 1 bit: a one-cycle pulse marking the cycle after a taken branch.
REQ-017 SHALL have port taken_cnt, output, CNT_W bits: the number of taken branches in the current run.
REQ-018 SHALL have port done, output, 1 bit: the program has halted.

Function
REQ-019 SHALL drive lut_index = tgt_sel combinationally, so the table result is usable in the same cycle.
REQ-020 SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE with start=1, set prog_ctr to 0, clear taken_cnt and move to RUN on the next edge.
REQ-022 SHALL drive fetch_valid=1 only in RUN and done=1 only in DONE, both as registered state decodes.
REQ-023 SHALL, in RUN with stall=1, hold prog_ctr, state and taken_cnt, hold branch_taken at 0, and ignore every other control input.
REQ-024 SHALL, in RUN with stall=0 and halt_req=1, hold prog_ctr and move to DONE, whatever the branch inputs are.
REQ-025 SHALL, in RUN with stall=0 and branch_abs=1 and cond_flag=1, load prog_ctr with lut_value zero-extended to PC_W.
REQ-026 SHALL, in RUN with stall=0 and branch_rel=1 and cond_flag=1, load prog_ctr with prog_ctr + sign-extended lut_value, modulo 2^PC_W.
REQ-027 SHALL give branch_abs priority when branch_abs and branch_rel are both asserted.
REQ-028 SHALL, when cond_flag=0, treat a branch as not taken and apply the sequential rule.
REQ-029 SHALL, in every other RUN cycle (sequential rule), set prog_ctr to prog_ctr+1, wrapping from 2^PC_W-1 to 0 with no error.
REQ-030 SHALL assert branch_taken for exactly one cycle, the cycle after a taken branch.
REQ-031 SHALL increment taken_cnt on each taken branch, saturating at 2^CNT_W-1.
REQ-032 SHALL ignore start while in RUN.
REQ-033 SHALL hold prog_ctr and taken_cnt in DONE; start=1 in DONE restarts exactly as REQ-021.

Reset
REQ-034 SHALL, while Reset_n=0, immediately force state=IDLE, prog_ctr=0, taken_cnt=0, branch_taken=0, fetch_valid=0 and done=0, regardless of Clk.
REQ-035 SHALL abandon any in-progress run on a reset asserted mid-RUN; no state survives reset.
REQ-036 SHALL, after Reset_n rises, remain in IDLE until start is sampled high.

Verification
REQ-037 Sequential run: reset, start pulse, 5 unstalled cycles -> prog_ctr steps 0,1,2,3,4,5; fetch_valid=1; taken_cnt=0.
REQ-038 Absolute jump: at prog_ctr=3 with branch_abs=1, cond_flag=1, tgt_sel=6, lut_value=70 -> next prog_ctr=70, branch_taken pulses once, taken_cnt=1.
REQ-039 Relative branch with wrap: prog_ctr=2 with branch_rel=1, cond_flag=1, lut_value=8'hFC -> next prog_ctr=1022 (PC_W=10); with cond_flag=0 -> next prog_ctr=3.
REQ-040 Priorities: halt_req, branch_abs and branch_rel all high with stall=1 -> no change; after stall drops -> DONE, done=1, prog_ctr held.
REQ-041 Reset mid-run: Reset_n pulled low between clock edges at prog_ctr=40 -> outputs zero at once; start afterwards restarts at 0.
REQ-042 Saturation: with CNT_W=2, five taken branches -> taken_cnt=3; start pulse from DONE -> taken_cnt=0, prog_ctr=0.
